mem_access_unit: RTL and testbench

//  Responder to the controller's memory-side signals (re_mem/we_mem/mem_op) and the execute-stage address and data.

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_enum;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } mem_state_enum;

  // Access width in bytes; MEM_NO reports 1 so it never looks misaligned.
  function automatic logic [3:0] mem_size_bytes(mem_op_enum op);
    case (op)
      MEM_H, MEM_UH: return 4'd2;
      MEM_W, MEM_UW: return 4'd4;
      MEM_D:         return 4'd8;
      default:       return 4'd1;
    endcase
  endfunction

  function automatic logic mem_is_unsigned(mem_op_enum op);
    return (op == MEM_UB) || (op == MEM_UH) || (op == MEM_UW);
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering for the 64-bit data bus: store lane shift and mask,
// load field extract and sign/zero extension.
// MEM_MISALIGN_CHECK_EN: flag misaligned accesses instead of forcing
// the offset to natural alignment.
module mem_data_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_enum  op,
  input  logic [2:0]  off_raw,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [63:0] wdata_lane,
  output logic [7:0]  wmask,
  output logic [63:0] rdata_ext,
  output logic        misaligned
);

  logic [3:0]  size;
  logic [2:0]  low_bits;
  logic [2:0]  off;
  logic [7:0]  base_mask;
  logic [63:0] field;
  logic        uns;

  // Lane shift, mask and load extension from the effective offset.
  always_comb begin
    size     = mem_size_bytes(op);
    low_bits = 3'(size - 4'd1);
    uns      = mem_is_unsigned(op);
`ifdef MEM_MISALIGN_CHECK_EN
    off        = off_raw;
    misaligned = (off_raw & low_bits) != 3'd0;
`else
    off        = off_raw & ~low_bits;
    misaligned = 1'b0;
`endif
    base_mask  = 8'((9'd1 << size) - 9'd1);
    wmask      = base_mask << off;
    wdata_lane = wdata << {off, 3'b000};
    field      = rdata_raw >> {off, 3'b000};
    case (size)
      4'd1:    rdata_ext = uns ? {56'd0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
      4'd2:    rdata_ext = uns ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
      4'd4:    rdata_ext = uns ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
      default: rdata_ext = field;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: accepts one core request at a time and runs it on
// the 64-bit data-memory bus. Misalignment behaviour is selected by
// MEM_MISALIGN_CHECK_EN inside mem_data_align.
//
// state  | meaning
// IDLE   | ready for a core request
// REQ    | mem_req held until mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid or timeout
// RESP   | one-cycle resp_valid pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  mem_op_enum        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  mem_state_enum     state, state_n;
  mem_op_enum        op_q, op_n, al_op;
  logic              we_q, we_n;
  logic [2:0]        off_q, off_n, al_off;
  logic [TW-1:0]     timer, timer_n;
  logic              req_ready_n, resp_valid_n, resp_err_n;
  logic [63:0]       resp_rdata_n, mem_wdata_n;
  logic              mem_req_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [7:0]        mem_wmask_n;
  logic [63:0]       al_wdata;
  logic [7:0]        al_wmask;
  logic [63:0]       al_rdata;
  logic              al_mis;

  // In IDLE the aligner sees the incoming request so bus outputs can be
  // registered at the handshake; afterwards it sees the latched op/offset.
  assign al_op  = (state == IDLE) ? req_op : op_q;
  assign al_off = (state == IDLE) ? req_addr[2:0] : off_q;

  mem_data_align u_align (
    .op         (al_op),
    .off_raw    (al_off),
    .wdata      (req_wdata),
    .rdata_raw  (mem_rdata),
    .wdata_lane (al_wdata),
    .wmask      (al_wmask),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  // State, request latch, timer and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      op_q       <= MEM_NO;
      we_q       <= 1'b0;
      off_q      <= 3'd0;
      timer      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 64'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 64'd0;
      mem_wmask  <= 8'd0;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      we_q       <= we_n;
      off_q      <= off_n;
      timer      <= timer_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wmask  <= mem_wmask_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    op_n         = op_q;
    we_n         = we_q;
    off_n        = off_q;
    timer_n      = timer;
    req_ready_n  = req_ready;
    resp_valid_n = 1'b0;
    resp_err_n   = resp_err;
    resp_rdata_n = resp_rdata;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wmask_n  = mem_wmask;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_n        = req_op;
          we_n        = req_we;
          off_n       = req_addr[2:0];
          req_ready_n = 1'b0;
          if (req_op == MEM_NO || al_mis) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = al_mis;
            resp_rdata_n = 64'd0;
          end else begin
            state_n     = REQ;
            mem_req_n   = 1'b1;
            mem_we_n    = req_we;
            mem_addr_n  = {req_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_n = req_we ? al_wdata : 64'd0;
            mem_wmask_n = req_we ? al_wmask : 8'd0;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          mem_addr_n  = '0;
          mem_wdata_n = 64'd0;
          mem_wmask_n = 8'd0;
          if (we_q) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b0;
            resp_rdata_n = 64'd0;
          end else if (mem_rvalid) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b0;
            resp_rdata_n = al_rdata;
          end else begin
            state_n = WAIT_R;
            timer_n = TW'(1);
          end
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = al_rdata;
          timer_n      = '0;
        end else if (TIMEOUT_CYCLES > 0 && timer == TMAX) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
          resp_rdata_n = 64'd0;
          timer_n      = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          timer_n = timer + TW'(1);
        end
      end
      RESP: begin
        state_n      = IDLE;
        req_ready_n  = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = 64'd0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized transactions against a byte-arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  mem_op_enum  req_op = MEM_NO;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on size/offset.
  function automatic int op_size(mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: return 1;
      MEM_H, MEM_UH: return 2;
      MEM_W, MEM_UW: return 4;
      MEM_D:         return 8;
      default:       return 1;
    endcase
  endfunction

  function automatic bit op_signed(mem_op_enum op);
    return op == MEM_B || op == MEM_H || op == MEM_W;
  endfunction

  function automatic bit exp_mis(mem_op_enum op, logic [63:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
    return (int'(addr[2:0]) % op_size(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eff_off(mem_op_enum op, logic [63:0] addr);
    int o = int'(addr[2:0]);
`ifdef MEM_MISALIGN_CHECK_EN
    return o;
`else
    return o - (o % op_size(op));
`endif
  endfunction

  function automatic logic [7:0] exp_mask(mem_op_enum op, logic [63:0] addr);
    return 8'(((1 << op_size(op)) - 1) << eff_off(op, addr));
  endfunction

  function automatic logic [63:0] exp_lane(mem_op_enum op, logic [63:0] addr, logic [63:0] wd);
    return wd << (8 * eff_off(op, addr));
  endfunction

  function automatic logic [63:0] exp_load(mem_op_enum op, logic [63:0] addr, logic [63:0] word);
    logic [127:0] f, keep;
    int s = op_size(op);
    f    = {64'd0, word} >> (8 * eff_off(op, addr));
    keep = (128'd1 << (8 * s)) - 128'd1;
    f    = f & keep;
    if (op_signed(op) && f[8*s-1]) f = f | ~keep;
    return f[63:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_rvalid"}, resp_valid, 0);
    check({tag, "_err"}, resp_err, 0);
    check({tag, "_rdata"}, resp_rdata, 0);
    check({tag, "_mreq"}, mem_req, 0);
    check({tag, "_mwe"}, mem_we, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_mwdata"}, mem_wdata, 0);
    check({tag, "_mwmask"}, mem_wmask, 0);
  endtask

  // rv_dly: 0 = rvalid with gnt, k = in k-th WAIT_R cycle, >TO = never.
  task automatic run_txn(input mem_op_enum op, input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [63:0] word, input bit late_rv);
    bit bus, tmo, hit;
    @(negedge clk);
    check("ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    bus = (op != MEM_NO) && !exp_mis(op, addr);
    if (!bus) begin
      check("nobus_resp", resp_valid, 1);
      check("nobus_err", resp_err, exp_mis(op, addr));
      check("nobus_rdata", resp_rdata, 0);
      check("nobus_mreq", mem_req, 0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, {addr[63:3], 3'b000});
        check("mem_we", mem_we, we);
        check("mem_wmask", mem_wmask, we ? exp_mask(op, addr) : 8'd0);
        if (we) check("mem_wdata", mem_wdata, exp_lane(op, addr, wd));
        check("req_no_resp", resp_valid, 0);
        if (i < gnt_dly) begin
          mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
        end else begin
          mem_gnt = 1'b1; mem_rvalid = !we && rv_dly == 0; mem_rdata = word;
        end
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!we && rv_dly != 0) begin
        for (int k = 1; k <= TO; k++) begin
          check("wait_no_resp", resp_valid, 0);
          check("wait_mreq", mem_req, 0);
          hit = (k == rv_dly);
          mem_rvalid = hit;
          mem_rdata = hit ? word : {$urandom, $urandom};
          @(negedge clk);
          mem_rvalid = 1'b0;
          if (hit) break;
        end
      end
      tmo = !we && rv_dly > TO;
      check("resp_valid", resp_valid, 1);
      check("resp_err", resp_err, tmo);
      check("resp_rdata", resp_rdata, (we || tmo) ? 64'd0 : exp_load(op, addr, word));
    end
    if (late_rv) begin
      mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("late_rv_resp", resp_valid, 0);
      check("late_rv_ready", req_ready, 1);
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rstn = 1'b1;

    run_txn(MEM_D, 1'b1, 64'h1000, 64'h1122334455667788, 0, 0, 64'd0, 1'b0);
    run_txn(MEM_B, 1'b0, 64'h2003, 64'h0000000080000000, 0, 0, 64'h0000000080000000, 1'b0);
    run_txn(MEM_UB, 1'b0, 64'h2003, 64'd0, 0, 2, 64'h0000000080000000, 1'b0);
    run_txn(MEM_H, 1'b1, 64'h3006, 64'hBEEF, 3, 0, 64'd0, 1'b0);
    run_txn(MEM_W, 1'b0, 64'h4004, 64'd0, 0, TO + 5, 64'h1234567800000000, 1'b1);
    run_txn(MEM_W, 1'b0, 64'h5002, 64'd0, 1, 1, 64'h8877665544332211, 1'b0);
    run_txn(MEM_NO, 1'b0, 64'h7777, 64'd0, 0, 0, 64'd0, 1'b0);
    run_txn(MEM_UW, 1'b0, 64'h8004, 64'd0, 2, TO, 64'hF00DCAFE12345678, 1'b0);

    // Reset while in WAIT_R
    @(negedge clk);
    req_valid = 1'b1; req_op = MEM_W; req_we = 1'b0; req_addr = 64'h6000;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rstn = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("postrst_resp", resp_valid, 0);
    check("postrst_ready", req_ready, 1);
    check("postrst_mreq", mem_req, 0);

    for (int n = 0; n < 60; n++) begin
      run_txn(mem_op_enum'(3'($urandom_range(0, 7))), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, TO + 2),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
